// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: redirect arbitration, PC register control
// and a single-outstanding instruction-memory handshake with decode buffer.
module fetch_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_addr,
    input  logic             ex_br_req,
    input  logic [XLEN-1:0]  ex_br_addr,
    input  logic             id_jmp_req,
    input  logic [XLEN-1:0]  id_jmp_addr,
    input  logic             id_stall,
    input  logic             halt_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             imem_req,
    output logic             pc_stall,
    output logic             pc_jump_flag,
    output logic [XLEN-1:0]  pc_jump_addr,
    output logic             if_valid,
    output logic [XLEN-1:0]  if_instr,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            sel_trap;
    logic            sel_br;
    logic            sel_jmp;
    logic            redir;
    logic [XLEN-1:0] redir_addr;

    // A stalled decode cannot own its jump, so ID only competes when free.
    always_comb begin
        sel_trap   = trap_req;
        sel_br     = ~trap_req & ex_br_req;
        sel_jmp    = ~trap_req & ~ex_br_req & id_jmp_req & ~id_stall;
        redir      = sel_trap | sel_br | sel_jmp;
        redir_addr = '0;
        unique case (1'b1)
            sel_trap: redir_addr = trap_addr;
            sel_br:   redir_addr = ex_br_addr;
            sel_jmp:  redir_addr = id_jmp_addr;
            default:  redir_addr = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        if (redir) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            S_FETCH: begin
                if (!redir) begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redir) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_VALID;
                        instr_d = imem_rdata;
                    end
                end else if (redir) begin
                    state_d = S_DRAIN;
                end
            end
            S_VALID: begin
                if (redir) begin
                    state_d = S_FETCH;
                    instr_d = '0;
                end else if (!id_stall) begin
                    state_d = S_FETCH;
                end
            end
            // The in-flight return belongs to the old path; swallow it.
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        pc_stall     = 1'b1;
        pc_jump_flag = 1'b0;
        pc_jump_addr = '0;
        if_valid     = 1'b0;
        if_instr     = '0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        halted       = 1'b0;
        redirect_cnt = '0;
        if (!rst) begin
            pc_jump_flag = redir;
            pc_jump_addr = redir_addr;
            flush_if_id  = redir;
            flush_id_ex  = sel_trap | sel_br;
            pc_stall     = ~(redir | ((state_q == S_VALID) & ~id_stall));
            imem_req     = (state_q == S_FETCH) & ~redir & ~halt_req;
            if_valid     = (state_q == S_VALID);
            if_instr     = instr_q;
            halted       = (state_q == S_HALT);
            redirect_cnt = cnt_q;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model checked every
// cycle plus hand-computed expectations along the documented scenarios.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        trap_req;
    logic [31:0] trap_addr;
    logic        ex_br_req;
    logic [31:0] ex_br_addr;
    logic        id_jmp_req;
    logic [31:0] id_jmp_addr;
    logic        id_stall;
    logic        halt_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic        pc_stall;
    logic        pc_jump_flag;
    logic [31:0] pc_jump_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [15:0] redirect_cnt;

    fetch_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .trap_req(trap_req), .trap_addr(trap_addr),
        .ex_br_req(ex_br_req), .ex_br_addr(ex_br_addr),
        .id_jmp_req(id_jmp_req), .id_jmp_addr(id_jmp_addr),
        .id_stall(id_stall), .halt_req(halt_req),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_req(imem_req),
        .pc_stall(pc_stall), .pc_jump_flag(pc_jump_flag),
        .pc_jump_addr(pc_jump_addr), .if_valid(if_valid),
        .if_instr(if_instr), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .halted(halted),
        .redirect_cnt(redirect_cnt)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: outstanding fetch, stale marker, a one-deep decode buffer,
    // halt flag and a plain redirect tally.
    bit          m_out;
    bit          m_stale;
    bit          m_buf_v;
    logic [31:0] m_buf;
    bit          m_halt;
    int          m_cnt;
    bit          seen_dead;
    logic [31:0] pc_env;
    logic [31:0] pc_nxt;

    initial begin
        m_out = 0; m_stale = 0; m_buf_v = 0; m_buf = '0;
        m_halt = 0; m_cnt = 0; seen_dead = 0;
        pc_env = '0; pc_nxt = '0;
    end

    always @(negedge clk) begin
        bit          e_redir, e_f1, e_f2, e_idle, e_req, e_stall;
        logic [31:0] e_addr;
        e_redir = 0; e_f1 = 0; e_f2 = 0; e_addr = '0;
        if (trap_req) begin
            e_redir = 1; e_f1 = 1; e_f2 = 1; e_addr = trap_addr;
        end else if (ex_br_req) begin
            e_redir = 1; e_f1 = 1; e_f2 = 1; e_addr = ex_br_addr;
        end else if (id_jmp_req && !id_stall) begin
            e_redir = 1; e_f1 = 1; e_addr = id_jmp_addr;
        end
        e_idle  = !m_out && !m_buf_v && !m_halt;
        e_req   = e_idle && !e_redir && !halt_req;
        e_stall = !(e_redir || (m_buf_v && !id_stall));
        if (rst) begin
            chk("m_imem_req", imem_req, 0);
            chk("m_pc_stall", pc_stall, 1);
            chk("m_jump_flag", pc_jump_flag, 0);
            chk("m_jump_addr", pc_jump_addr, 0);
            chk("m_if_valid", if_valid, 0);
            chk("m_if_instr", if_instr, 0);
            chk("m_flush_if_id", flush_if_id, 0);
            chk("m_flush_id_ex", flush_id_ex, 0);
            chk("m_halted", halted, 0);
        end else begin
            chk("m_imem_req", imem_req, e_req);
            chk("m_pc_stall", pc_stall, e_stall);
            chk("m_jump_flag", pc_jump_flag, e_redir);
            chk("m_jump_addr", pc_jump_addr, e_addr);
            chk("m_if_valid", if_valid, m_buf_v);
            if (m_buf_v) chk("m_if_instr", if_instr, m_buf);
            chk("m_flush_if_id", flush_if_id, e_f1);
            chk("m_flush_id_ex", flush_id_ex, e_f2);
            chk("m_halted", halted, m_halt);
            chk("m_redirect_cnt", redirect_cnt, m_cnt);
        end
        if (if_valid && if_instr == 32'hDEADBEEF) seen_dead = 1;

        if (rst) pc_nxt = '0;
        else if (!pc_stall) pc_nxt = pc_jump_flag ? pc_jump_addr : pc_env + 4;
        else pc_nxt = pc_env;

        if (rst) begin
            m_out = 0; m_stale = 0; m_buf_v = 0; m_halt = 0; m_cnt = 0;
        end else begin
            if (e_redir) m_cnt = (m_cnt + 1) % 65536;
            if (m_buf_v && (e_redir || !id_stall)) m_buf_v = 0;
            if (m_out && imem_rvalid) begin
                if (!m_stale && !e_redir) begin
                    m_buf_v = 1;
                    m_buf = imem_rdata;
                end
                m_out = 0;
                m_stale = 0;
            end else if (m_out && e_redir) begin
                m_stale = 1;
            end
            if (e_req && imem_gnt) begin
                m_out = 1;
                m_stale = 0;
            end
            if (m_halt && !halt_req) m_halt = 0;
            else if (e_idle && !e_redir && halt_req) m_halt = 1;
        end
    end

    // External PC register driven by the DUT's control outputs.
    always @(posedge clk) pc_env <= pc_nxt;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    initial begin
        rst = 1; trap_req = 0; trap_addr = '0; ex_br_req = 0;
        ex_br_addr = '0; id_jmp_req = 0; id_jmp_addr = '0;
        id_stall = 0; halt_req = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = '0;
        nxt();
        nxt();
        peek();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_stall", pc_stall, 1);
        chk("rst_if_valid", if_valid, 0);
        nxt();

        // Basic fetch: req/gnt, rvalid, consume
        rst = 0; imem_gnt = 1;
        peek();
        chk("c1_imem_req", imem_req, 1);
        chk("c1_pc", pc_env, 0);
        nxt();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        peek();
        chk("c2_pc_stall", pc_stall, 1);
        nxt();
        imem_rvalid = 0;
        peek();
        chk("c3_if_valid", if_valid, 1);
        chk("c3_if_instr", if_instr, 32'h0000_0013);
        chk("c3_pc_stall", pc_stall, 0);
        nxt();

        // Decode stall holds the buffer
        imem_gnt = 1;
        peek();
        chk("c4_pc", pc_env, 4);
        nxt();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0010_0093;
        nxt();
        imem_rvalid = 0; id_stall = 1;
        for (int i = 0; i < 4; i++) begin
            peek();
            chk("stall_if_valid", if_valid, 1);
            chk("stall_if_instr", if_instr, 32'h0010_0093);
            chk("stall_pc_stall", pc_stall, 1);
            nxt();
        end
        id_stall = 0;
        peek();
        chk("adv_pc_stall", pc_stall, 0);
        nxt();

        // Branch while waiting: drain the stale return
        imem_gnt = 1;
        peek();
        chk("c11_pc", pc_env, 8);
        nxt();
        imem_gnt = 0; ex_br_req = 1; ex_br_addr = 32'h100;
        peek();
        chk("br_jump_flag", pc_jump_flag, 1);
        chk("br_jump_addr", pc_jump_addr, 32'h100);
        chk("br_flush_id_ex", flush_id_ex, 1);
        nxt();
        ex_br_req = 0;
        peek();
        chk("drain_jump_flag", pc_jump_flag, 0);
        chk("drain_pc", pc_env, 32'h100);
        nxt();
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
        nxt();
        imem_rvalid = 0;
        peek();
        chk("post_drain_if_valid", if_valid, 0);
        chk("post_drain_imem_req", imem_req, 1);
        chk("post_drain_pc", pc_env, 32'h100);
        nxt();

        // Arbitration priority
        trap_req = 1; trap_addr = 32'h80;
        ex_br_req = 1; ex_br_addr = 32'h200;
        id_jmp_req = 1; id_jmp_addr = 32'h300;
        peek();
        chk("seen_dead", {31'd0, seen_dead}, 0);
        chk("prio_addr", pc_jump_addr, 32'h80);
        chk("prio_flush_if_id", flush_if_id, 1);
        chk("prio_flush_id_ex", flush_id_ex, 1);
        chk("prio_cnt_before", redirect_cnt, 1);
        nxt();
        trap_req = 0; ex_br_req = 0; id_stall = 1;
        peek();
        chk("prio_cnt_after", redirect_cnt, 2);
        chk("prio_pc", pc_env, 32'h80);
        chk("jmp_stalled_flag", pc_jump_flag, 0);
        chk("jmp_stalled_flush", flush_if_id, 0);
        nxt();
        id_stall = 0;
        peek();
        chk("jmp_addr", pc_jump_addr, 32'h300);
        chk("jmp_flush_if_id", flush_if_id, 1);
        chk("jmp_flush_id_ex", flush_id_ex, 0);
        nxt();

        // Debug halt with a trap while parked
        id_jmp_req = 0; halt_req = 1;
        peek();
        chk("halt_req_imem", imem_req, 0);
        chk("halt_pc", pc_env, 32'h300);
        nxt();
        trap_req = 1; trap_addr = 32'h40;
        peek();
        chk("halt_halted", halted, 1);
        chk("halt_trap_flag", pc_jump_flag, 1);
        nxt();
        trap_req = 0;
        peek();
        chk("halt_still", halted, 1);
        chk("halt_trap_pc", pc_env, 32'h40);
        chk("halt_no_req", imem_req, 0);
        nxt();
        halt_req = 0;
        peek();
        chk("release_halted", halted, 1);
        nxt();
        peek();
        chk("resume_halted", halted, 0);
        chk("resume_req", imem_req, 1);
        chk("resume_pc", pc_env, 32'h40);
        chk("resume_cnt", redirect_cnt, 4);
        nxt();

        // Counter wrap
        trap_addr = 32'h40;
        for (int i = 0; i < 65531; i++) begin
            trap_req = 1;
            nxt();
        end
        trap_req = 0;
        peek();
        chk("cnt_max", redirect_cnt, 32'hFFFF);
        nxt();
        trap_req = 1;
        nxt();
        trap_req = 0;
        peek();
        chk("cnt_wrap", redirect_cnt, 0);
        nxt();

        // Reset while a fetch is outstanding
        imem_gnt = 1;
        peek();
        chk("pre_rst_req", imem_req, 1);
        nxt();
        imem_gnt = 0; rst = 1;
        peek();
        chk("wait_rst_req", imem_req, 0);
        chk("wait_rst_stall", pc_stall, 1);
        nxt();
        rst = 0; imem_rvalid = 1; imem_rdata = 32'h0BAD_C0DE;
        peek();
        chk("late_rvalid_req", imem_req, 1);
        chk("late_rvalid_cnt", redirect_cnt, 0);
        nxt();
        imem_rvalid = 0;
        peek();
        chk("late_rvalid_ignored", if_valid, 0);
        nxt();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
